// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares the instruction ROM read port between the CPU fetch and debug requesters
// Fixed CPU priority; a starvation counter forces a debug grant after STARVE_LIMIT lost contested cycles.
module rom_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_data,
  input  logic              dbg_req_valid,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  output logic              dbg_req_ready,
  output logic              dbg_resp_valid,
  output logic [DATA_W-1:0] dbg_resp_data,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              resp_pend_q, resp_pend_d;
  logic              resp_id_q, resp_id_d;
  logic [ADDR_W-1:0] addr_shadow_q, addr_shadow_d;
  logic              gnt0, gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (cpu_req_valid && dbg_req_valid) begin
        if (starve_cnt_q >= LIMIT) gnt1 = 1'b1;
        else                       gnt0 = 1'b1;
      end else begin
        gnt0 = cpu_req_valid;
        gnt1 = dbg_req_valid;
      end
    end

    // A debug grant clears the count even when it coincides with saturation.
    starve_cnt_d = starve_cnt_q;
    if (gnt1)
      starve_cnt_d = 4'd0;
    else if (gnt0 && dbg_req_valid && starve_cnt_q < LIMIT)
      starve_cnt_d = starve_cnt_q + 4'd1;

    resp_pend_d = gnt0 | gnt1;
    resp_id_d   = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : resp_id_q);

    addr_shadow_d = addr_shadow_q;
    if (rst)       addr_shadow_d = '0;
    else if (gnt1) addr_shadow_d = dbg_req_addr;
    else if (gnt0) addr_shadow_d = cpu_req_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q  <= 4'd0;
      resp_pend_q   <= 1'b0;
      resp_id_q     <= 1'b0;
      addr_shadow_q <= '0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      resp_pend_q   <= resp_pend_d;
      resp_id_q     <= resp_id_d;
      addr_shadow_q <= addr_shadow_d;
    end
  end

  assign cpu_req_ready = gnt0;
  assign dbg_req_ready = gnt1;
  assign rom_ce        = gnt0 | gnt1;
  assign rom_addr      = addr_shadow_d;

  // Gating by rst suppresses a response whose grant preceded the reset cycle.
  assign cpu_resp_valid = !rst && resp_pend_q && !resp_id_q;
  assign dbg_resp_valid = !rst && resp_pend_q && resp_id_q;
  assign cpu_resp_data  = cpu_resp_valid ? rom_data : '0;
  assign dbg_resp_data  = dbg_resp_valid ? rom_data : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - scoreboard bench for rom_port_arbiter with a behavioural ROM and grant model
module tb_rom_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cv = 1'b0, dv = 1'b0;
  logic [31:0] ca = '0, da = '0;
  logic        cpu_req_ready, cpu_resp_valid, dbg_req_ready, dbg_resp_valid, rom_ce;
  logic [31:0] cpu_resp_data, dbg_resp_data, rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cv), .cpu_req_addr(ca), .cpu_req_ready(cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .dbg_req_valid(dv), .dbg_req_addr(da), .dbg_req_ready(dbg_req_ready),
    .dbg_resp_valid(dbg_resp_valid), .dbg_resp_data(dbg_resp_data),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_ce) rom_data <= mem[rom_addr[9:2]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: count of contested cycles the debug port has lost since its last grant.
  int          lost = 0;
  logic [31:0] shadow = '0;
  always @(negedge clk) begin
    bit g0, g1;
    exp_t e;
    if (cyc >= 1) begin
      if (rst) begin
        chk("rst_cpu_ready", cpu_req_ready, 0);
        chk("rst_dbg_ready", dbg_req_ready, 0);
        chk("rst_rom_ce", rom_ce, 0);
        chk("rst_rom_addr", rom_addr, 0);
        lost   = 0;
        shadow = '0;
      end else begin
        g0 = cv && (!dv || lost < LIMIT);
        g1 = dv && !g0;
        chk("cpu_ready", cpu_req_ready, g0);
        chk("dbg_ready", dbg_req_ready, g1);
        chk("rom_ce", rom_ce, g0 | g1);
        if (g1) shadow = da;
        else if (g0) shadow = ca;
        chk("rom_addr", rom_addr, shadow);
        if (g0 || g1) begin
          e.port = g1;
          e.data = mem[shadow[9:2]];
          e.due  = cyc + 1;
          q.push_back(e);
        end
        if (g1) lost = 0;
        else if (g0 && dv && lost < LIMIT) lost = lost + 1;
      end
    end
  end

  // Monitor: pops the response due this cycle and compares it to what the DUT presents.
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      if (rst) begin
        chk("rst_cpu_resp_valid", cpu_resp_valid, 0);
        chk("rst_dbg_resp_valid", dbg_resp_valid, 0);
        chk("rst_cpu_resp_data", cpu_resp_data, 0);
        chk("rst_dbg_resp_data", dbg_resp_data, 0);
        while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      end else if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("cpu_resp_valid", cpu_resp_valid, !e.port);
        chk("dbg_resp_valid", dbg_resp_valid, e.port);
        chk("cpu_resp_data", cpu_resp_data, e.port ? 32'h0 : e.data);
        chk("dbg_resp_data", dbg_resp_data, e.port ? e.data : 32'h0);
      end else begin
        chk("idle_cpu_resp_valid", cpu_resp_valid, 0);
        chk("idle_dbg_resp_valid", dbg_resp_valid, 0);
        chk("idle_cpu_resp_data", cpu_resp_data, 0);
        chk("idle_dbg_resp_data", dbg_resp_data, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0]  pat;
    logic [9:0]  pat_exp;
    logic        r0, r1;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h34011100;
    mem[1] = 32'h34020020;
    mem[2] = 32'h3403ff00;

    // Reset held with both ports requesting.
    rst = 1'b1; cv = 1'b1; dv = 1'b1; ca = 32'h0; da = 32'h100;
    repeat (3) step();

    // CPU streaming 0x0, 0x4, 0x8 straight out of reset.
    rst = 1'b0; dv = 1'b0;
    ca = 32'h0; step();
    ca = 32'h4; step();
    ca = 32'h8; step();
    cv = 1'b0; repeat (2) step();

    // Both ports held valid for 10 cycles.
    cv = 1'b1; dv = 1'b1; ca = 32'h0; da = 32'h100;
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat[i] = dbg_req_ready;
      r0 = cpu_req_ready;
      step();
      if (r0) ca = ca + 32'h4;
    end
    pat_exp = '0;
    pat_exp[4] = 1'b1;
    pat_exp[9] = 1'b1;
    chk("starve_pattern", pat, pat_exp);
    cv = 1'b0; dv = 1'b0; step();

    // Lone debug request, then contention to confirm the counter started from zero.
    dv = 1'b1; da = 32'h40; step();
    dv = 1'b0; step();
    cv = 1'b1; dv = 1'b1; ca = 32'h10; da = 32'h44;
    repeat (6) step();
    cv = 1'b0; dv = 1'b0; step();

    // Idle hold of the address shadow.
    cv = 1'b1; ca = 32'h8; step();
    cv = 1'b0; repeat (3) step();

    // Reset arriving the cycle after a CPU grant.
    cv = 1'b1; ca = 32'hC; step();
    rst = 1'b1; cv = 1'b0; step();
    rst = 1'b0; cv = 1'b1; dv = 1'b1; ca = 32'h20; da = 32'h24;
    repeat (7) step();
    cv = 1'b0; dv = 1'b0; step();

    // Randomised traffic; a requester that was not granted keeps valid and address.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r0 = cpu_req_ready;
      r1 = dbg_req_ready;
      step();
      if (!(cv && !r0)) begin
        cv = ($urandom_range(0, 9) < 6);
        ca = {22'h0, 8'($urandom), 2'b00};
      end
      if (!(dv && !r1)) begin
        dv = ($urandom_range(0, 9) < 5);
        da = {22'h0, 8'($urandom), 2'b00};
      end
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0; cv = 1'b0; dv = 1'b0;
    repeat (3) step();
    chk("queue_drained", 64'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
